// File: rtl/alu_adder_pkg.sv
// ---------------------------------------------------------------------------
// alu_adder_pkg
//   Shared definitions for the alu_adder block.
//   - msb_of(): MSB index helper for a WIDTH-bit operand.
//   - op_e: operation select, only used when ALU_ADDER_SUB_EN is defined.
// ---------------------------------------------------------------------------
package alu_adder_pkg;

  // Default operand width of the block.
  localparam int ALU_ADDER_DEFAULT_WIDTH = 8;

  // Index of the most significant bit for a given width.
  function automatic int msb_of(input int width);
    return width - 1;
  endfunction

  // Operation select (subtract support is optional).
  typedef enum logic [0:0] {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/alu_adder_core.sv
// ---------------------------------------------------------------------------
// adder_core
//   Purely combinational WIDTH-bit adder with carry-in.
//   Ports:
//     x, y          operands (y already inverted by the caller for subtract)
//     cin           carry-in (1 for subtract, 0 for add)
//     sum           x + y + cin, truncated to WIDTH bits
//     carry         raw carry-out of the MSB
//     ovf_unsigned  unsigned overflow: carry on add, borrow (~carry) on subtract
//     ovf_signed    two's-complement overflow
// ---------------------------------------------------------------------------
module adder_core
  import alu_adder_pkg::*;
#(
  parameter int WIDTH = ALU_ADDER_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf_unsigned,
  output logic             ovf_signed
);

  localparam int MSB = msb_of(WIDTH);

  logic [WIDTH:0] full;

  // Zero-extended WIDTH+1 bit sum; the top bit is the raw carry-out.
  assign full  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];

  // cin is only ever set for subtract, where a missing carry means a borrow,
  // so XOR-ing with cin yields carry for add and ~carry for subtract.
  assign ovf_unsigned = carry ^ cin;

  // Same-sign operands (after y inversion) whose sum changes sign overflowed.
  // For subtract this is exactly "x and original y differ in sign".
  assign ovf_signed = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);

endmodule

// File: rtl/alu_adder.sv
// ---------------------------------------------------------------------------
// alu_adder
//   Registered two-operand adder with carry and overflow flags.
//   Parameters:
//     WIDTH   operand/result width (>= 2)
//     SIGNED  0 = unsigned overflow rule, 1 = two's-complement overflow rule
//   Ports:
//     in_clk, in_rst       clock, synchronous active-high reset
//     in_valid             operands valid this cycle
//     in_x, in_y           operands
//     in_sub               subtract select (only with ALU_ADDER_SUB_EN)
//     out_valid            result valid (one cycle after in_valid)
//     out_result           registered sum, mod 2^WIDTH
//     out_carry            registered raw MSB carry-out
//     out_overflow         registered overflow flag
//   Configuration macro: ALU_ADDER_SUB_EN adds in_sub and X - Y support.
//
//   Handshake: valid-only, no ready. A beat is accepted on every rising edge
//   where in_valid=1 and in_rst=0; its result appears after that edge with
//   out_valid=1 for exactly one cycle. There is no backpressure or stall.
//   When in_valid=0 the data outputs hold and out_valid drops.
// ---------------------------------------------------------------------------
module alu_adder
  import alu_adder_pkg::*;
#(
  parameter int WIDTH  = ALU_ADDER_DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
`ifdef ALU_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow
);

  logic [WIDTH-1:0] y_eff;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf_unsigned;
  logic             ovf_signed;
  logic             ovf_sel;

`ifdef ALU_ADDER_SUB_EN
  op_e op;
  assign op = in_sub ? OP_SUB : OP_ADD;

  // Subtract is x + ~y + 1 through the same adder.
  assign y_eff = (op == OP_SUB) ? ~in_y : in_y;
  assign cin   = (op == OP_SUB);
`else
  assign y_eff = in_y;
  assign cin   = 1'b0;
`endif

  adder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x            (in_x),
    .y            (y_eff),
    .cin          (cin),
    .sum          (sum),
    .carry        (carry),
    .ovf_unsigned (ovf_unsigned),
    .ovf_signed   (ovf_signed)
  );

  assign ovf_sel = SIGNED ? ovf_signed : ovf_unsigned;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_result   <= sum;
        out_carry    <= carry;
        out_overflow <= ovf_sel;
      end
    end
  end

endmodule

// File: tb/tb_alu_adder.sv
// ---------------------------------------------------------------------------
// tb_alu_adder
//   Bench for alu_adder at WIDTH=8 with one unsigned and one signed instance
//   sharing the same stimulus. A behavioural model based on integer
//   arithmetic produces expected values that are queued and compared one
//   cycle later. ALU_ADDER_SUB_EN enables the subtract tests.
// ---------------------------------------------------------------------------
module tb_alu_adder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         sub;

  always #5 clk = ~clk;

  logic         u_valid, s_valid;
  logic [W-1:0] u_res, s_res;
  logic         u_carry, s_carry;
  logic         u_ovf, s_ovf;

  alu_adder #(.WIDTH(W), .SIGNED(1'b0)) u_uns (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_y         (in_y),
`ifdef ALU_ADDER_SUB_EN
    .in_sub       (sub),
`endif
    .out_valid    (u_valid),
    .out_result   (u_res),
    .out_carry    (u_carry),
    .out_overflow (u_ovf)
  );

  alu_adder #(.WIDTH(W), .SIGNED(1'b1)) u_sgn (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_y         (in_y),
`ifdef ALU_ADDER_SUB_EN
    .in_sub       (sub),
`endif
    .out_valid    (s_valid),
    .out_result   (s_res),
    .out_carry    (s_carry),
    .out_overflow (s_ovf)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // Packed expectation: {valid, carry, ovf_unsigned, ovf_signed, result}
  logic [W+3:0] exp_q[$];

  // Model state: what the outputs should currently show.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic         m_carry = 1'b0;
  logic         m_ovu   = 1'b0;
  logic         m_ovs   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: real integer arithmetic, overflow from range checks.
  task automatic model_update(input logic v, input logic r, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic s);
    int  ux, uy, sx, sy, tot, st;
    logic do_sub;
`ifdef ALU_ADDER_SUB_EN
    do_sub = s;
`else
    do_sub = 1'b0;
    if (s) do_sub = 1'b0;
`endif
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (r) begin
      m_valid = 1'b0; m_res = '0; m_carry = 1'b0; m_ovu = 1'b0; m_ovs = 1'b0;
    end else if (v) begin
      m_valid = 1'b1;
      if (do_sub) begin
        tot     = ux - uy;
        m_res   = W'((tot + 256) % 256);
        m_carry = (ux >= uy);
        m_ovu   = (ux < uy);
        st      = sx - sy;
      end else begin
        tot     = ux + uy;
        m_res   = W'(tot % 256);
        m_carry = (tot > 255);
        m_ovu   = (tot > 255);
        st      = sx + sy;
      end
      m_ovs = (st > 127) || (st < -128);
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_valid, m_carry, m_ovu, m_ovs, m_res});
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs, clock it, then compare both instances.
  task automatic step(input logic v, input logic r, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic s);
    logic [W+3:0] e;
    in_valid = v; rst = r; in_x = x; in_y = y; sub = s;
    model_update(v, r, x, y, s);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("uns_valid",  32'(u_valid), 32'(e[W+3]));
    check("uns_result", 32'(u_res),   32'(e[W-1:0]));
    check("uns_carry",  32'(u_carry), 32'(e[W+2]));
    check("uns_ovf",    32'(u_ovf),   32'(e[W+1]));
    check("sgn_valid",  32'(s_valid), 32'(e[W+3]));
    check("sgn_result", 32'(s_res),   32'(e[W-1:0]));
    check("sgn_carry",  32'(s_carry), 32'(e[W+2]));
    check("sgn_ovf",    32'(s_ovf),   32'(e[W]));
  endtask

  logic [W-1:0] rx, ry;
  logic         rs;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; sub = 1'b0;

    // Reset held with valid operands present.
    step(1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    step(1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    check("rst_valid", 32'(u_valid), 32'd0);
    check("rst_res",   32'(u_res),   32'd0);
    check("rst_ovf",   32'(s_ovf),   32'd0);

    // 200 + 100
    step(1'b1, 1'b0, 8'hC8, 8'h64, 1'b0);
    check("c8_64_res",   32'(u_res),   32'h2C);
    check("c8_64_carry", 32'(u_carry), 32'd1);
    check("c8_64_uovf",  32'(u_ovf),   32'd1);
    step(1'b1, 1'b0, 8'h10, 8'h20, 1'b0);
    check("10_20_res",  32'(u_res), 32'h30);
    check("10_20_uovf", 32'(u_ovf), 32'd0);

    // 100 + 100 signed
    step(1'b1, 1'b0, 8'h64, 8'h64, 1'b0);
    check("64_64_res",   32'(s_res),   32'hC8);
    check("64_64_carry", 32'(s_carry), 32'd0);
    check("64_64_sovf",  32'(s_ovf),   32'd1);
    // -128 + -1
    step(1'b1, 1'b0, 8'h80, 8'hFF, 1'b0);
    check("80_ff_res",   32'(s_res),   32'h7F);
    check("80_ff_carry", 32'(s_carry), 32'd1);
    check("80_ff_sovf",  32'(s_ovf),   32'd1);
    // -1 + 1
    step(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);
    check("ff_01_res",  32'(s_res), 32'h00);
    check("ff_01_sovf", 32'(s_ovf), 32'd0);
    check("ff_01_uovf", 32'(u_ovf), 32'd1);

    // Drop valid for 3 cycles: data holds.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0);
      check("hold_res", 32'(u_res), 32'h00);
    end

`ifdef ALU_ADDER_SUB_EN
    step(1'b1, 1'b0, 8'h05, 8'h07, 1'b1);
    check("sub_05_07_res",   32'(u_res),   32'hFE);
    check("sub_05_07_carry", 32'(u_carry), 32'd0);
    check("sub_05_07_uovf",  32'(u_ovf),   32'd1);
    check("sub_05_07_sovf",  32'(s_ovf),   32'd0);
    step(1'b1, 1'b0, 8'h80, 8'h01, 1'b1);
    check("sub_80_01_res",  32'(s_res), 32'h7F);
    check("sub_80_01_sovf", 32'(s_ovf), 32'd1);
`endif

    // Random back-to-back stream with one mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      step(1'b1, (i == 500), rx, ry, rs);
      if (i == 500) begin
        check("midrst_valid", 32'(s_valid), 32'd0);
        check("midrst_res",   32'(s_res),   32'd0);
      end
    end

    // Drop valid for 3 cycles after the stream.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0);
      check("drop_valid", 32'(u_valid), 32'd0);
    end

    // Random valid pattern.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_adder.md
Name: alu_adder

Overview:
- Parameterised two-operand integer adder with carry and overflow flags, for the rv32i datapath (ALU add path, address/PC arithmetic).
- One registered output stage: operands and flags are sampled on a clock edge and presented one cycle later.
- SIGNED is a per-instance parameter: the same RTL serves as an unsigned or a two's-complement adder. Only the overflow definition changes between the two modes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥2 (datapath instance uses 32).
- SIGNED, 0, 0 = operands are unsigned, 1 = operands are two's complement; selects the overflow rule.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle.
- in_x  input  WIDTH  operand X.
- in_y  input  WIDTH  operand Y.
- out_valid  output  1  registered result valid.
- out_result  output  WIDTH  registered sum, truncated to WIDTH bits (X+Y mod 2^WIDTH).
- out_carry  output  1  registered carry-out of the MSB.
- out_overflow  output  1  registered overflow flag; the rule depends on SIGNED.

Behaviour:
- Reset: at a rising edge with in_rst=1, out_valid, out_result, out_carry and out_overflow are all cleared to 0. Reset takes priority over in_valid.
- Reset mid-stream: the in-flight result is discarded. The first valid output after reset comes from the first in_valid=1 cycle that has in_rst=0.
- Core sum:
  - {c, s} = in_x + in_y, computed at WIDTH+1 bits with zero extension in both modes.
  - s drives out_result; c drives out_carry.
  - out_carry is the raw MSB carry in both modes.
- Overflow, SIGNED=0: out_overflow = c (unsigned wrap).
- Overflow, SIGNED=1: out_overflow = (x[MSB] == y[MSB]) && (s[MSB] != x[MSB]).
  - Adding operands of opposite sign never overflows.
- Latency:
  - When in_valid=1 at edge N, the result and flags are visible after edge N, with out_valid=1.
  - Back-to-back valid inputs give one result per cycle; there is no stall and no backpressure.
- When in_valid=0 at an edge: out_valid goes 0, and out_result/out_carry/out_overflow hold their previous values.
- There is no combinational path from any input to any output.
- Inputs containing X/Z are not defined behaviour; the bench must drive only 0/1.

Optional Feature:
- Macro ALU_ADDER_SUB_EN.
- With the macro defined:
  - Adds input port in_sub (1 bit).
  - When in_sub=1, the operation is X − Y, implemented as in_x + ~in_y + 1 through the same WIDTH+1 path.
  - out_carry is the raw carry-out (1 = no borrow).
  - Unsigned overflow = ~c (borrow).
  - Signed overflow = (x[MSB] != y[MSB]) && (s[MSB] != x[MSB]).
  - in_sub is sampled with in_valid.
- Without the macro: no in_sub port; addition only, exactly as described above.

Decomposition:
- Package alu_adder_pkg holds:
  - localparam helpers for the MSB index;
  - an enum for operation (OP_ADD, OP_SUB), used only when ALU_ADDER_SUB_EN is defined.
- Sub-module adder_core: purely combinational WIDTH-bit add with carry-in. Outputs are sum and carry, plus signed and unsigned overflow.
- The top level instantiates adder_core and adds the output register, valid and reset logic.

Test Plan (WIDTH=8):
- Reset: hold in_rst=1 for 2 cycles with in_valid=1, in_x=0x55, in_y=0x55 → all outputs 0 and out_valid=0. Assert in_rst for one cycle mid-stream → the next-cycle outputs are 0.
- SIGNED=0: 0xC8+0x64 (200+100) → out_result=0x2C, out_carry=1, out_overflow=1. Then 0x10+0x20 → 0x30, carry 0, overflow 0.
- SIGNED=1: 0x64+0x64 (100+100) → 0xC8, carry 0, overflow 1. Then 0x80+0xFF (−128+−1) → 0x7F, carry 1, overflow 1.
- SIGNED=1: 0xFF+0x01 → 0x00, carry 1, overflow 0. The same operands with SIGNED=0 → overflow 1.
- Stream and hold:
  - Apply random in_x/in_y with in_valid=1 every cycle for 1000 cycles. Compare against a WIDTH+1 reference model with exactly 1-cycle latency, for both instances.
  - Drop in_valid for 3 cycles → out_valid=0 and the data holds.
- ALU_ADDER_SUB_EN: in_sub=1, 0x05−0x07 → out_result=0xFE, out_carry=0.
  - Unsigned overflow=1; signed overflow=0.
  - 0x80−0x01 with SIGNED=1 → 0x7F, overflow=1.
